// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants and types for the MIPS-style execute core.
//               Holds the opcode and R-type function codes, the ALU operation
//               enum and the decode helper that maps opc/func to an operation.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = 5;

  // Major opcodes
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_SLTIU = 6'b001011;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_NOR  = 4'd6,
    ALU_SLT  = 4'd7,
    ALU_SLTU = 4'd8,
    ALU_SLL  = 4'd9,
    ALU_SRL  = 4'd10,
    ALU_SRA  = 4'd11
  } alu_op_t;

  // Map opcode/function to an ALU operation. Anything unrecognised yields
  // ALU_NONE, which the ALU reports as an invalid operation.
  function automatic alu_op_t decode_op(input logic [5:0] opc, input logic [5:0] func);
    alu_op_t op;
    op = ALU_NONE;
    if (opc == OPC_RTYPE) begin
      case (func)
        FN_ADD, FN_ADDU: op = ALU_ADD;
        FN_SUB, FN_SUBU: op = ALU_SUB;
        FN_AND:          op = ALU_AND;
        FN_OR:           op = ALU_OR;
        FN_XOR:          op = ALU_XOR;
        FN_NOR:          op = ALU_NOR;
        FN_SLT:          op = ALU_SLT;
        FN_SLTU:         op = ALU_SLTU;
        FN_SLL:          op = ALU_SLL;
        FN_SRL:          op = ALU_SRL;
        FN_SRA:          op = ALU_SRA;
        default:         op = ALU_NONE;
      endcase
    end else begin
      case (opc)
        OPC_ADDI, OPC_ADDIU: op = ALU_ADD;
        OPC_SLTI:            op = ALU_SLT;
        OPC_SLTIU:           op = ALU_SLTU;
        OPC_ANDI:            op = ALU_AND;
        OPC_ORI:             op = ALU_OR;
        OPC_XORI:            op = ALU_XOR;
        default:             op = ALU_NONE;
      endcase
    end
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_alu.sv
`default_nettype none
// ============================================================================
// Module      : mips_alu
// Description : Purely combinational ALU for the execute core.
// Ports       : a_i      - operand A
//               b_i      - operand B (register value or zero-extended imm)
//               op_i     - ALU operation
//               result_o - operation result
//               valid_o  - high when op_i is a real operation
// Revision    : 1.0 - initial release
// ============================================================================
module mips_alu
  import mips_pkg::*;
#(
  parameter int XLEN = mips_pkg::XLEN
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  alu_op_t         op_i,
  output logic [XLEN-1:0] result_o,
  output logic            valid_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    valid_o  = 1'b1;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_NOR:  result_o = ~(a_i | b_i);
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      default: begin
        result_o = '0;
        valid_o  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_exec_top.sv
`default_nettype none
// ============================================================================
// Module      : mips_exec_top
// Description : Single-cycle MIPS-style execute core. Every rising edge it
//               decodes opc/func, reads operands from a 32x32 register file,
//               writes the ALU result back to reg[Number1] and registers it
//               on exit. r0 reads as zero and ignores writes.
// Ports       : clock   - system clock (rising edge)
//               reset_n - asynchronous active-low reset
//               opc     - major opcode (000000 = R-type)
//               func    - R-type function code
//               Number1 - operand A index and destination index
//               Number2 - operand B index (R-type) or 5-bit immediate
//               exit    - registered result of last valid operation
// Revision    : 1.0 - initial release
// ============================================================================
module mips_exec_top
  import mips_pkg::*;
#(
  parameter int XLEN  = mips_pkg::XLEN,
  parameter int NREGS = mips_pkg::NREGS
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [5:0]      opc,
  input  logic [5:0]      func,
  input  logic [4:0]      Number1,
  input  logic [4:0]      Number2,
  output logic [XLEN-1:0] exit
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] exit_q;
  logic [XLEN-1:0] exit_d;

  alu_op_t         alu_op;
  logic            use_imm;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic            alu_valid;

  assign alu_op  = decode_op(opc, func);
  assign use_imm = (opc != OPC_RTYPE);

  // Reads see the pre-edge register contents; r0 is forced to zero here so
  // its storage element never matters.
  assign op_a = (Number1 == 5'd0) ? '0 : regs_q[Number1];
  assign op_b = use_imm            ? {{(XLEN-5){1'b0}}, Number2}
              : (Number2 == 5'd0)  ? '0 : regs_q[Number2];

  mips_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .a_i      (op_a),
    .b_i      (op_b),
    .op_i     (alu_op),
    .result_o (alu_res),
    .valid_o  (alu_valid)
  );

  // Invalid operations leave exit holding its previous value.
  assign exit_d = alu_valid ? alu_res : exit_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exit_q <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= XLEN'(i);
      end
    end else begin
      exit_q <= exit_d;
      if (alu_valid && (Number1 != 5'd0)) begin
        regs_q[Number1] <= alu_res;
      end
    end
  end

  assign exit = exit_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_exec_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_exec_top
// Description : Directed self-checking bench for mips_exec_top.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_exec_top;
  import mips_pkg::*;

  typedef struct {
    logic [5:0]  o;
    logic [5:0]  f;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [31:0] e;
  } vec_t;

  logic        clock;
  logic        reset_n;
  logic [5:0]  opc;
  logic [5:0]  func;
  logic [4:0]  n1;
  logic [4:0]  n2;
  logic [31:0] exit_w;

  int total;
  int bad;

  mips_exec_top dut (
    .clock   (clock),
    .reset_n (reset_n),
    .opc     (opc),
    .func    (func),
    .Number1 (n1),
    .Number2 (n2),
    .exit    (exit_w)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drive one operation, let one rising edge execute it, sample 1ns later.
  task automatic do_op(input logic [5:0] o, input logic [5:0] f,
                       input logic [4:0] a, input logic [4:0] b);
    opc  = o;
    func = f;
    n1   = a;
    n2   = b;
    @(posedge clock);
    #1;
  endtask

  // Hold reset across one edge, release well away from the next edge.
  task automatic apply_reset();
    reset_n = 1'b0;
    @(posedge clock);
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    opc = OPC_RTYPE; func = FN_ADD; n1 = 5'd2; n2 = 5'd3;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    total++;
    if (exit_w !== 32'd0) begin
      bad++;
      $display("FAIL reset_exit: got %h want %h", exit_w, 32'd0);
    end
    // still low across another edge with a valid op driven: must stay 0
    @(posedge clock);
    #1;
    total++;
    if (exit_w !== 32'd0) begin
      bad++;
      $display("FAIL reset_held: got %h want %h", exit_w, 32'd0);
    end
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_r0();
    vec_t v [2];
    apply_reset();
    v = '{'{OPC_RTYPE, FN_ADD, 5'd0, 5'd1, 32'd1},
          '{OPC_RTYPE, FN_ADD, 5'd0, 5'd1, 32'd1}};
    foreach (v[i]) begin
      do_op(v[i].o, v[i].f, v[i].a, v[i].b);
      total++;
      if (exit_w !== v[i].e) begin
        bad++;
        $display("FAIL r0_add[%0d]: got %h want %h", i, exit_w, v[i].e);
      end
    end
  endtask

  task automatic test_accumulate();
    logic [31:0] exp [3];
    apply_reset();
    exp = '{32'd5, 32'd8, 32'd11};
    for (int i = 0; i < 3; i++) begin
      do_op(OPC_RTYPE, FN_ADD, 5'd2, 5'd3);
      total++;
      if (exit_w !== exp[i]) begin
        bad++;
        $display("FAIL accum[%0d]: got %h want %h", i, exit_w, exp[i]);
      end
    end
  endtask

  // Sequences run from a fresh reset; comments give register values.
  task automatic test_rtype();
    vec_t v [13];
    v = '{'{OPC_RTYPE, FN_SUB,  5'd1,  5'd2,  32'hFFFF_FFFF}, // r1=1-2
          '{OPC_RTYPE, FN_SLTU, 5'd3,  5'd1,  32'd1},         // 3 <u FFFFFFFF
          '{OPC_RTYPE, FN_SLT,  5'd4,  5'd1,  32'd0},         // 4 <s -1 false
          '{OPC_RTYPE, FN_SLT,  5'd5,  5'd6,  32'd1},         // 5 < 6
          '{OPC_RTYPE, FN_AND,  5'd6,  5'd3,  32'd0},         // r6=6 & r3(1)
          '{OPC_RTYPE, FN_OR,   5'd7,  5'd10, 32'd15},        // 7 | 10
          '{OPC_RTYPE, FN_XOR,  5'd12, 5'd10, 32'd6},         // 12 ^ 10
          '{OPC_RTYPE, FN_NOR,  5'd9,  5'd8,  32'hFFFF_FFF6}, // ~(9|8)
          '{OPC_RTYPE, FN_ADDU, 5'd11, 5'd13, 32'd24},        // 11 + 13
          '{OPC_RTYPE, FN_SUBU, 5'd14, 5'd15, 32'hFFFF_FFFF}, // 14 - 15
          '{OPC_RTYPE, FN_ADD,  5'd20, 5'd13, 32'd33},        // r20=33
          '{OPC_RTYPE, FN_SLL,  5'd16, 5'd20, 32'd32},        // 16 << (33&31)
          '{OPC_RTYPE, FN_SLT,  5'd1,  5'd0,  32'd1}};        // -1 < 0
    apply_reset();
    foreach (v[i]) begin
      do_op(v[i].o, v[i].f, v[i].a, v[i].b);
      total++;
      if (exit_w !== v[i].e) begin
        bad++;
        $display("FAIL rtype[%0d] opc=%b func=%b: got %h want %h",
                 i, v[i].o, v[i].f, exit_w, v[i].e);
      end
    end
  endtask

  task automatic test_shifts();
    vec_t v [4];
    v = '{'{OPC_RTYPE, FN_SLL, 5'd1, 5'd31, 32'h8000_0000}, // r1 = 1<<31
          '{OPC_RTYPE, FN_SRA, 5'd1, 5'd4,  32'hF800_0000}, // arithmetic
          '{OPC_RTYPE, FN_SLL, 5'd2, 5'd30, 32'h8000_0000}, // r2 = 2<<30
          '{OPC_RTYPE, FN_SRL, 5'd2, 5'd4,  32'h0800_0000}};// logical
    apply_reset();
    foreach (v[i]) begin
      do_op(v[i].o, v[i].f, v[i].a, v[i].b);
      total++;
      if (exit_w !== v[i].e) begin
        bad++;
        $display("FAIL shift[%0d] func=%b: got %h want %h",
                 i, v[i].f, exit_w, v[i].e);
      end
    end
  endtask

  task automatic test_itype();
    vec_t v [9];
    v = '{'{OPC_ADDI,  6'h3F, 5'd4, 5'd31, 32'd35}, // func ignored
          '{OPC_ORI,   6'h00, 5'd4, 5'd2,  32'd35},
          '{OPC_ANDI,  6'h00, 5'd4, 5'd3,  32'd3},
          '{OPC_XORI,  6'h00, 5'd4, 5'd31, 32'd28},
          '{OPC_ADDIU, 6'h00, 5'd4, 5'd4,  32'd32},
          '{OPC_SLTI,  6'h00, 5'd4, 5'd31, 32'd0},  // 32 < 31 false, r4=0
          '{OPC_SLTIU, 6'h00, 5'd8, 5'd9,  32'd1},
          '{OPC_RTYPE, FN_SUB, 5'd1, 5'd2, 32'hFFFF_FFFF},
          '{OPC_SLTIU, 6'h00, 5'd1, 5'd5,  32'd0}}; // FFFFFFFF <u 5 false
    apply_reset();
    foreach (v[i]) begin
      do_op(v[i].o, v[i].f, v[i].a, v[i].b);
      total++;
      if (exit_w !== v[i].e) begin
        bad++;
        $display("FAIL itype[%0d] opc=%b: got %h want %h",
                 i, v[i].o, exit_w, v[i].e);
      end
    end
  endtask

  task automatic test_undefined();
    vec_t v [5];
    v = '{'{OPC_RTYPE, FN_ADD, 5'd3, 5'd4, 32'd7},
          '{OPC_RTYPE, 6'h3F,  5'd3, 5'd4, 32'd7},  // undefined func
          '{OPC_RTYPE, 6'h3F,  5'd3, 5'd4, 32'd7},
          '{6'b000100, FN_ADD, 5'd3, 5'd4, 32'd7},  // undefined opc
          '{OPC_RTYPE, FN_OR,  5'd3, 5'd0, 32'd7}}; // r3 untouched
    apply_reset();
    foreach (v[i]) begin
      do_op(v[i].o, v[i].f, v[i].a, v[i].b);
      total++;
      if (exit_w !== v[i].e) begin
        bad++;
        $display("FAIL undef[%0d]: got %h want %h", i, exit_w, v[i].e);
      end
    end
  endtask

  task automatic test_midreset();
    apply_reset();
    do_op(OPC_RTYPE, FN_ADD, 5'd2, 5'd3);
    do_op(OPC_RTYPE, FN_ADD, 5'd2, 5'd3);
    total++;
    if (exit_w !== 32'd8) begin
      bad++;
      $display("FAIL midrst_pre: got %h want %h", exit_w, 32'd8);
    end
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (exit_w !== 32'd0) begin
      bad++;
      $display("FAIL midrst_async: got %h want %h", exit_w, 32'd0);
    end
    #1;
    reset_n = 1'b1;
    // first edge after release runs the held add on restored r2=2
    @(posedge clock);
    #1;
    total++;
    if (exit_w !== 32'd5) begin
      bad++;
      $display("FAIL midrst_first: got %h want %h", exit_w, 32'd5);
    end
    do_op(OPC_RTYPE, FN_OR, 5'd12, 5'd0);
    total++;
    if (exit_w !== 32'd12) begin
      bad++;
      $display("FAIL midrst_r12: got %h want %h", exit_w, 32'd12);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b1;
    opc     = OPC_RTYPE;
    func    = FN_ADD;
    n1      = 5'd0;
    n2      = 5'd0;
    #2;
    test_reset();
    test_r0();
    test_accumulate();
    test_rtype();
    test_shifts();
    test_itype();
    test_undefined();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_exec_top.md
Name: mips_exec_top

Overview:
Single-cycle MIPS-style execute core for bring-up and ALU verification. It holds a 32x32 register file. Each clock edge it applies one opcode/function to the registers selected by Number1/Number2, writes the result back, and presents the result on exit. No instruction memory; the bench drives opcode fields directly.

Parameters:
- XLEN, 32, datapath and register width.
- NREGS, 32, register count; register index width is 5.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opc  in  6  major opcode; 000000 = R-type.
- func  in  6  R-type function code; ignored when opc is not 000000.
- Number1  in  5  operand A register index; also the destination register.
- Number2  in  5  operand B: register index for R-type, 5-bit zero-extended immediate for I-type.
- exit  out  32  registered result of the last executed valid operation.

Behaviour:
- Reset (reset_n=0, asynchronous): exit=0. reg[i]=i for i=0..31. Held while low.
- r0 is hardwired to 0: reads return 0 and writes are dropped.
- Operand fetch: A=reg[Number1]. B=reg[Number2] (R-type) or {27'b0,Number2} (I-type).
- Each rising edge, for a valid op: exit<=result, reg[Number1]<=result. Latency is one edge; the result is visible after the edge at which the inputs were sampled.
- Same-edge read-before-write: operands use pre-edge register values.
- R-type func codes (opc=000000):
  - 100000 add and 100001 addu: A+B, wrap mod 2^32, no overflow trap.
  - 100010 sub and 100011 subu: A-B, wrap.
  - 100100 and, 100101 or, 100110 xor, 100111 nor.
  - 101010 slt: signed A<B ? 1 : 0.
  - 101011 sltu: unsigned compare.
  - 000000 sll: A << B[4:0].
  - 000010 srl: A >> B[4:0], logical.
  - 000011 sra: A >>> B[4:0], arithmetic.
- I-type opc codes:
  - 001000 addi and 001001 addiu: A+imm.
  - 001010 slti: signed compare vs imm. 001011 sltiu: unsigned compare vs imm.
  - 001100 andi, 001101 ori, 001110 xori.
- Undefined opc or func: no register write, exit holds its previous value.
- Inputs held constant: the operation re-executes every edge, so accumulation is intended (e.g. add r2,r3 repeats).
- Reset asserted mid-stream: immediately restores reset values. The first edge after release executes the current inputs.

Decomposition:
- Shared package mips_pkg:
  - opcode constants: OPC_RTYPE, OPC_ADDI, etc.
  - func constants: FN_ADD, FN_SUB, etc.
  - ALU operation enum alu_op_t.
  - XLEN.
- Sub-module mips_alu: combinational, inputs a, b, alu_op_t; outputs result and a valid flag.
- Top level holds decode, register file and exit register.

Test Plan:
- Reset, then opc=0, func=100000, N1=0, N2=1 -> exit=1 after first edge. Stays 1 on subsequent edges because r0 is unwritable.
- Reset, add with N1=2, N2=3 -> exit=5 on edge 1, 8 on edge 2, 11 on edge 3 (r2 accumulates).
- Reset, one edge each:
  - sub N1=1, N2=2 -> 0xFFFFFFFF.
  - slt N1=5, N2=6 -> 1, since r5 and r6 are still 5 and 6.
  - sra on a register holding 0x80000000 by 4 -> 0xF8000000.
- Reset, opc=001000, N1=4, N2=31 -> exit=35, r4=35. Then opc=001101, N1=4, N2=2 -> 35|2=35.
- Undefined func 111111 after a valid op leaving exit=7 -> exit stays 7, no register changes.
- reset_n pulsed low between edges mid-accumulation -> exit=0 immediately, all registers back to index values.
